// File: rtl/lab7_pkg.sv
// Shared bus definitions for the lab 7 CPU data bus and its peripherals.
package lab7_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SW_W   = 10;
    localparam int unsigned KEY_W  = 4;

    // Bus command encoding; 2'b11 is not listed and decodes as no operation.
    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    localparam logic [ADDR_W-1:0] LEDADDR = 9'h100;
    localparam logic [ADDR_W-1:0] SWADDR  = 9'h140;
    localparam logic [ADDR_W-1:0] KEYADDR = 9'h141;

endpackage

// File: rtl/debounce_bit.sv
// One board input bit: 2-flop synchroniser followed by a stability counter.
module debounce_bit #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter logic        RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then accept a new level only after DEB_CYCLES stable cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= RESET_VAL;
            s     <= RESET_VAL;
            deb   <= RESET_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            if (s == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_io.sv
// Memory-mapped board I/O: LED register, debounced switches, sticky key presses.
module mmio_io
    import lab7_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              read_en,
    input  logic [SW_W-1:0]   SW,
    input  logic [KEY_W-1:0]  KEY,
    output logic [SW_W-1:0]   LEDR
);

    logic [SW_W-1:0]  sw_deb;
    logic [KEY_W-1:0] key_deb;
    logic [KEY_W-1:0] key_prev;
    logic [KEY_W-1:0] key_evt_q;
    logic [KEY_W-1:0] key_fall;
    logic [KEY_W-1:0] key_evt;
    logic             led_wr;
    logic             key_rd;

    // Switch conditioning, released level is 0.
    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES),
            .RESET_VAL  (1'b0)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (SW[i]),
            .deb   (sw_deb[i])
        );
    end

    // Key conditioning, keys are active-low so released level is 1.
    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES),
            .RESET_VAL  (1'b1)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (KEY[i]),
            .deb   (key_deb[i])
        );
    end

    assign led_wr = (mem_cmd == MWRITE) && (mem_addr == LEDADDR);
    assign key_rd = (mem_cmd == MREAD)  && (mem_addr == KEYADDR);

    // A press is visible from the edge where key_deb falls; key_prev lags by one edge,
    // so the fall term covers that first cycle until key_evt_q captures it.
    assign key_fall = key_prev & ~key_deb;
    assign key_evt  = key_evt_q | key_fall;

    // LED register write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            LEDR <= '0;
        end else if (led_wr) begin
            LEDR <= write_data[SW_W-1:0];
        end
    end

    // Sticky key events; a read clears everything it reported, a later fall still sets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_prev  <= '1;
            key_evt_q <= '0;
        end else begin
            key_prev <= key_deb;
            if (key_rd) begin
                key_evt_q <= '0;
            end else begin
                key_evt_q <= key_evt;
            end
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        read_en   = 1'b0;
        read_data = '0;
        if (mem_cmd == MREAD) begin
            if (mem_addr == SWADDR) begin
                read_en   = 1'b1;
                read_data = DATA_W'(sw_deb);
            end else if (mem_addr == KEYADDR) begin
                read_en   = 1'b1;
                read_data = DATA_W'(key_evt);
            end
        end
    end

endmodule

// File: tb/tb_mmio_io.sv
// Scoreboard bench for mmio_io: stimulus pushes expectations, a negedge monitor checks them.
module tb_mmio_io;
    import lab7_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_en;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [9:0]  LEDR;

    typedef struct {
        string       name;
        logic        chk_bus;
        logic        exp_en;
        logic [15:0] exp_data;
        logic        chk_led;
        logic [9:0]  exp_led;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic txn_valid;
    int   n_tests;
    int   n_fail;

    mmio_io #(.DEB_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .read_en    (read_en),
        .SW         (SW),
        .KEY        (KEY),
        .LEDR       (LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: checks the DUT against the oldest expectation mid-cycle.
    always @(negedge clk) begin
        if (txn_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: transaction seen with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk_bus) begin
                    n_tests++;
                    if (read_en !== mon_e.exp_en || read_data !== mon_e.exp_data) begin
                        n_fail++;
                        $display("FAIL %s: read_en=%0b read_data=%h, expected read_en=%0b read_data=%h",
                                 mon_e.name, read_en, read_data, mon_e.exp_en, mon_e.exp_data);
                    end
                end
                if (mon_e.chk_led) begin
                    n_tests++;
                    if (LEDR !== mon_e.exp_led) begin
                        n_fail++;
                        $display("FAIL %s: LEDR=%h, expected %h", mon_e.name, LEDR, mon_e.exp_led);
                    end
                end
            end
        end
    end

    // Advance past the next rising edge and return the bus to idle.
    task automatic step();
        @(posedge clk);
        #1;
        mem_cmd   = MNONE;
        txn_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_read(input string name, input logic [8:0] addr,
                            input logic en, input logic [15:0] data);
        exp_t e;
        step();
        mem_cmd  = MREAD;
        mem_addr = addr;
        e.name = name; e.chk_bus = 1'b1; e.exp_en = en; e.exp_data = data;
        e.chk_led = 1'b0; e.exp_led = '0;
        sb.push_back(e);
        txn_valid = 1'b1;
    endtask

    task automatic bus_write(input logic [8:0] addr, input logic [15:0] data);
        step();
        mem_cmd    = MWRITE;
        mem_addr   = addr;
        write_data = data;
    endtask

    task automatic check_led(input string name, input logic [9:0] led);
        exp_t e;
        step();
        e.name = name; e.chk_bus = 1'b0; e.exp_en = 1'b0; e.exp_data = '0;
        e.chk_led = 1'b1; e.exp_led = led;
        sb.push_back(e);
        txn_valid = 1'b1;
    endtask

    initial begin
        exp_t e;
        n_tests    = 0;
        n_fail     = 0;
        txn_valid  = 1'b0;
        reset      = 1'b0;
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        SW         = '0;
        KEY        = 4'hF;

        // Reset state.
        bus_read("rst_sw", SWADDR, 1'b1, 16'h0000);
        bus_read("rst_key", KEYADDR, 1'b1, 16'h0000);
        check_led("rst_led", 10'h000);
        step();
        reset = 1'b1;
        idle(2);

        // LED write and decode.
        bus_write(LEDADDR, 16'hFEA5);
        check_led("led_write", 10'h2A5);
        bus_write(SWADDR, 16'hFFFF);
        check_led("led_wr_sw_ignored", 10'h2A5);
        bus_write(KEYADDR, 16'hFFFF);
        check_led("led_wr_key_ignored", 10'h2A5);
        bus_write(9'h101, 16'h0000);
        check_led("led_wr_other_ignored", 10'h2A5);
        bus_read("rd_ledaddr", LEDADDR, 1'b0, 16'h0000);
        bus_read("rd_unmapped_005", 9'h005, 1'b0, 16'h0000);
        bus_read("rd_unmapped_1ff", 9'h1FF, 1'b0, 16'h0000);
        bus_write(9'h005, 16'h0000);
        mem_cmd = 2'b11;
        mem_addr = SWADDR;
        e.name = "cmd11_as_none"; e.chk_bus = 1'b1; e.exp_en = 1'b0; e.exp_data = '0;
        e.chk_led = 1'b0; e.exp_led = '0;
        sb.push_back(e);
        txn_valid = 1'b1;

        // Switch debounce latency: visible from edge 6 after the change.
        SW = 10'h155;
        for (int k = 1; k <= 8; k++)
            bus_read($sformatf("sw_lat_e%0d", k), SWADDR, 1'b1, (k >= 6) ? 16'h0155 : 16'h0000);

        // 3-cycle glitch on SW[0] is rejected.
        SW = 10'h154;
        idle(3);
        SW = 10'h155;
        for (int k = 1; k <= 8; k++)
            bus_read($sformatf("sw_glitch_%0d", k), SWADDR, 1'b1, 16'h0155);

        // Key press latency and read-to-clear.
        KEY = 4'b1011;
        for (int k = 1; k <= 7; k++)
            bus_read($sformatf("key_lat_e%0d", k), KEYADDR, 1'b1, (k == 6) ? 16'h0004 : 16'h0000);
        idle(10);
        bus_read("key_hold_no_retrig", KEYADDR, 1'b1, 16'h0000);
        KEY = 4'hF;
        idle(10);
        bus_read("key_release_no_evt", KEYADDR, 1'b1, 16'h0000);

        // Sticky event held across idle cycles, then cleared.
        KEY = 4'b0111;
        idle(12);
        bus_read("key_sticky", KEYADDR, 1'b1, 16'h0008);
        bus_read("key_reread", KEYADDR, 1'b1, 16'h0000);
        KEY = 4'hF;
        idle(10);

        // Press lands on the edge ending a clearing read: set wins.
        KEY = 4'b1110;
        idle(4);
        bus_read("key_set_vs_clr_old", KEYADDR, 1'b1, 16'h0000);
        bus_read("key_set_vs_clr_new", KEYADDR, 1'b1, 16'h0001);
        bus_read("key_set_vs_clr_after", KEYADDR, 1'b1, 16'h0000);
        KEY = 4'hF;
        idle(10);

        // Mid-run reset with live state: LED, switches and a pending key event.
        bus_write(LEDADDR, 16'h03FF);
        check_led("led_all_on", 10'h3FF);
        KEY = 4'b1101;
        idle(10);
        step();
        reset    = 1'b0;
        KEY      = 4'hF;
        mem_cmd  = MREAD;
        mem_addr = SWADDR;
        e.name = "midrst_sw_led"; e.chk_bus = 1'b1; e.exp_en = 1'b1; e.exp_data = '0;
        e.chk_led = 1'b1; e.exp_led = '0;
        sb.push_back(e);
        txn_valid = 1'b1;
        bus_read("midrst_key", KEYADDR, 1'b1, 16'h0000);
        step();
        reset = 1'b1;
        SW = '0;
        idle(3);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
